exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline; consumes the ID/EX pipeline register outputs directly.
- Resolves forwarded operands, decodes ALU control from ALUOp/func3/func7, computes the ALU result and branch decision/target.
- Registers results into the EX/MEM pipeline register, with stall (hold) and flush (bubble) control.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RADDR_W, 5, register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- EXEALUSrc_in, EXEMemtoReg_in, EXERegWrite_in, EXEMemRead_in, EXEMemWrite_in, EXEBranch_in  input  1 each  control bits from ID/EX.
- EXEALUOp_in  input  2  ALU op class.
- EXEPC_in, EXERd1_in, EXERd2_in, EXEImmGen_in  input  32  PC, rs1/rs2 data, sign-extended immediate.
- EXEfunc3_in  input  3; EXEfunc7_in  input  1 (instr bit 30); EXERd_in  input  5.
- fwd_a_sel, fwd_b_sel  input  2  00 = ID/EX data, 01 = WB result, 10 = MEM result, 11 = ID/EX data.
- mem_fwd_data, wb_fwd_data  input  32  forwarding sources.
- stall  input  1  hold the EX/MEM register.
- flush  input  1  load a bubble into the EX/MEM register.
- branch_taken_o  output  1  combinational taken decision.
- branch_target_o  output  32  combinational PC + imm.
- MEMMemtoReg_out, MEMRegWrite_out, MEMMemRead_out, MEMMemWrite_out  output  1 each  registered.
- MEMALUResult_out, MEMStoreData_out  output  32  registered.
- MEMfunc3_out  output  3  registered; MEMRd_out  output  5  registered.

Behaviour:
- Operand A = forwarding-mux(EXERd1_in, fwd_a_sel).
- Forwarded rs2 = forwarding-mux(EXERd2_in, fwd_b_sel).
- Operand B = EXEALUSrc_in ? EXEImmGen_in : forwarded rs2.
- Store data = forwarded rs2, regardless of ALUSrc.
- ALU control by ALUOp:
  - 00: ADD.
  - 01: SUB.
  - 10 (R-type) by func3: 000 ADD, or SUB when func7=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when func7=1; 110 OR; 111 AND.
  - 11 (I-type): same as 10, except func3=000 is always ADD (func7 ignored). func7 applies only to func3=101.
- Arithmetic:
  - Results wrap modulo 2^32; no overflow flag.
  - Shift amount = B[4:0].
  - SLT compares signed, SLTU unsigned; both produce 32'd0 or 32'd1.
  - SRA sign-fills.
- Branch decision (combinational, uses forwarded A and forwarded rs2):
  - Taken when EXEBranch_in=1 and the func3 condition holds: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - func3 010/011 is never taken.
- branch_target_o = EXEPC_in + EXEImmGen_in, wrapping; always driven.
- branch_taken_o is not gated by stall; the upstream hazard unit masks it.
- EX/MEM register update on posedge clk, priority reset > flush > stall > load:
  - reset (rst=0, asynchronous): every MEM* output is 0.
  - flush=1: every MEM* output is 0 (bubble), even if stall=1.
  - stall=1, flush=0: all MEM* outputs hold.
  - otherwise: load the control bits, ALU result, store data, func3 and rd.
- MEMRegWrite_out loads as EXERegWrite_in AND (EXERd_in != 0); rd=x0 never asserts a write.
- Latency: one cycle from EX inputs to MEM* outputs; branch outputs have zero latency.
- Reset released mid-run: the first posedge after deassertion loads normally; no extra bubble.

Test Plan:
- Reset: rst=0 mid-operation -> all MEM* outputs 0 immediately, without a clock edge; after rst=1, the next edge loads the presented inputs.
- R-type: ALUOp=10, func3=000, func7=1, Rd1=5, Rd2=7 -> MEMALUResult=0xFFFFFFFE. Then func3=101, func7=1, Rd1=0x80000000, Rd2=4 -> 0xF8000000.
- I-type and forwarding: ALUOp=11, func3=000, func7=1, ALUSrc=1, imm=-1, fwd_a_sel=10, mem_fwd_data=0x10 -> MEMALUResult=0x0F. Also fwd_b_sel=01, wb_fwd_data=0xAB, MemWrite=1 -> MEMStoreData=0xAB.
- Branch: Branch=1, func3=100, A=0xFFFFFFFF, B=1, PC=0x100, imm=0xFFFFFFF8 -> branch_taken_o=1, target=0xF8. func3=110 with the same operands -> taken=0. func3=010 -> taken=0.
- Stall/flush: stall=1 for 2 cycles -> outputs hold their prior values. stall=1 and flush=1 together -> all outputs 0.
- rd=x0: RegWrite=1, Rd=0 -> MEMRegWrite_out=0. Rd=3 -> MEMRegWrite_out=1 and MEMRd_out=3.

Source files
------------

// File: rtl/exe_stage.sv
// RISC-V execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module exe_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EXEALUSrc_in,
  input  logic               EXEMemtoReg_in,
  input  logic               EXERegWrite_in,
  input  logic               EXEMemRead_in,
  input  logic               EXEMemWrite_in,
  input  logic               EXEBranch_in,
  input  logic [1:0]         EXEALUOp_in,
  input  logic [XLEN-1:0]    EXEPC_in,
  input  logic [XLEN-1:0]    EXERd1_in,
  input  logic [XLEN-1:0]    EXERd2_in,
  input  logic [XLEN-1:0]    EXEImmGen_in,
  input  logic [2:0]         EXEfunc3_in,
  input  logic               EXEfunc7_in,
  input  logic [RADDR_W-1:0] EXERd_in,
  input  logic [1:0]         fwd_a_sel,
  input  logic [1:0]         fwd_b_sel,
  input  logic [XLEN-1:0]    mem_fwd_data,
  input  logic [XLEN-1:0]    wb_fwd_data,
  input  logic               stall,
  input  logic               flush,
  output logic               branch_taken_o,
  output logic [XLEN-1:0]    branch_target_o,
  output logic               MEMMemtoReg_out,
  output logic               MEMRegWrite_out,
  output logic               MEMMemRead_out,
  output logic               MEMMemWrite_out,
  output logic [XLEN-1:0]    MEMALUResult_out,
  output logic [XLEN-1:0]    MEMStoreData_out,
  output logic [2:0]         MEMfunc3_out,
  output logic [RADDR_W-1:0] MEMRd_out
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctl_e;

  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    rs2_fwd;
  logic [XLEN-1:0]    op_b;
  logic [XLEN-1:0]    alu_result;
  logic [SHAMT_W-1:0] shamt;
  alu_ctl_e           alu_ctl;
  logic               br_eq;
  logic               br_lt;
  logic               br_ltu;
  logic               br_cond;

  // Select 01 = WB, 10 = MEM; 00 and 11 both keep the ID/EX value.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [XLEN-1:0] idex,
                                              input logic [1:0]      sel);
    case (sel)
      2'b01:   fwd_mux = wb_fwd_data;
      2'b10:   fwd_mux = mem_fwd_data;
      default: fwd_mux = idex;
    endcase
  endfunction

  assign op_a    = fwd_mux(EXERd1_in, fwd_a_sel);
  assign rs2_fwd = fwd_mux(EXERd2_in, fwd_b_sel);
  assign op_b    = EXEALUSrc_in ? EXEImmGen_in : rs2_fwd;
  assign shamt   = op_b[SHAMT_W-1:0];

  // ALU control decode; func7 only selects SUB on R-type ADD and SRA on shifts right.
  always_comb begin
    alu_ctl = ALU_ADD;
    case (EXEALUOp_in)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      default: begin
        case (EXEfunc3_in)
          3'b000:  alu_ctl = (EXEALUOp_in == 2'b10 && EXEfunc7_in) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctl = ALU_SLL;
          3'b010:  alu_ctl = ALU_SLT;
          3'b011:  alu_ctl = ALU_SLTU;
          3'b100:  alu_ctl = ALU_XOR;
          3'b101:  alu_ctl = EXEfunc7_in ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctl = ALU_OR;
          default: alu_ctl = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_result = op_a + op_b;
    case (alu_ctl)
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SLT:  alu_result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_result = XLEN'(op_a < op_b);
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:   alu_result = op_a | op_b;
      ALU_AND:  alu_result = op_a & op_b;
      default:  alu_result = op_a + op_b;
    endcase
  end

  // Branch compares always use forwarded rs2, never the immediate.
  assign br_eq  = (op_a == rs2_fwd);
  assign br_lt  = ($signed(op_a) < $signed(rs2_fwd));
  assign br_ltu = (op_a < rs2_fwd);

  always_comb begin
    br_cond = 1'b0;
    case (EXEfunc3_in)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = !br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = !br_lt;
      3'b110:  br_cond = br_ltu;
      3'b111:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign branch_taken_o  = EXEBranch_in && br_cond;
  assign branch_target_o = EXEPC_in + EXEImmGen_in;

  // EX/MEM register: flush beats stall; writes to x0 are suppressed here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEMMemtoReg_out  <= 1'b0;
      MEMRegWrite_out  <= 1'b0;
      MEMMemRead_out   <= 1'b0;
      MEMMemWrite_out  <= 1'b0;
      MEMALUResult_out <= '0;
      MEMStoreData_out <= '0;
      MEMfunc3_out     <= '0;
      MEMRd_out        <= '0;
    end else if (flush) begin
      MEMMemtoReg_out  <= 1'b0;
      MEMRegWrite_out  <= 1'b0;
      MEMMemRead_out   <= 1'b0;
      MEMMemWrite_out  <= 1'b0;
      MEMALUResult_out <= '0;
      MEMStoreData_out <= '0;
      MEMfunc3_out     <= '0;
      MEMRd_out        <= '0;
    end else if (!stall) begin
      MEMMemtoReg_out  <= EXEMemtoReg_in;
      MEMRegWrite_out  <= EXERegWrite_in && (EXERd_in != '0);
      MEMMemRead_out   <= EXEMemRead_in;
      MEMMemWrite_out  <= EXEMemWrite_in;
      MEMALUResult_out <= alu_result;
      MEMStoreData_out <= rs2_fwd;
      MEMfunc3_out     <= EXEfunc3_in;
      MEMRd_out        <= EXERd_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: ALU/forwarding/branch table plus
// hand-written stall, flush and mid-run reset sequences.
module tb_exe_stage;

  logic        clk, rst;
  logic        alusrc, memtoreg, regwrite, memread, memwrite, branch;
  logic [1:0]  aluop, fa, fb;
  logic [31:0] pc, rd1, rd2, imm, memd, wbd;
  logic [2:0]  f3;
  logic        f7;
  logic [4:0]  rd;
  logic        stall, flush;
  logic        taken;
  logic [31:0] target;
  logic        o_memtoreg, o_regwrite, o_memread, o_memwrite;
  logic [31:0] o_res, o_store;
  logic [2:0]  o_f3;
  logic [4:0]  o_rd;

  int checks = 0;
  int failures = 0;

  exe_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .EXEALUSrc_in(alusrc), .EXEMemtoReg_in(memtoreg), .EXERegWrite_in(regwrite),
    .EXEMemRead_in(memread), .EXEMemWrite_in(memwrite), .EXEBranch_in(branch),
    .EXEALUOp_in(aluop), .EXEPC_in(pc), .EXERd1_in(rd1), .EXERd2_in(rd2),
    .EXEImmGen_in(imm), .EXEfunc3_in(f3), .EXEfunc7_in(f7), .EXERd_in(rd),
    .fwd_a_sel(fa), .fwd_b_sel(fb), .mem_fwd_data(memd), .wb_fwd_data(wbd),
    .stall(stall), .flush(flush),
    .branch_taken_o(taken), .branch_target_o(target),
    .MEMMemtoReg_out(o_memtoreg), .MEMRegWrite_out(o_regwrite),
    .MEMMemRead_out(o_memread), .MEMMemWrite_out(o_memwrite),
    .MEMALUResult_out(o_res), .MEMStoreData_out(o_store),
    .MEMfunc3_out(o_f3), .MEMRd_out(o_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7, alusrc;
    logic [31:0] rd1, rd2, imm, pc, memd, wbd;
    logic [1:0]  fa, fb;
    logic        branch, regwrite, memwrite, memread, memtoreg;
    logic [4:0]  rd;
    logic [31:0] e_res, e_store, e_target;
    logic        e_regw, e_taken;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t base(logic [1:0] op, logic [2:0] fn3, logic fn7, logic src,
                                logic [31:0] a, logic [31:0] b, logic [31:0] im,
                                logic [31:0] res);
    vec_t v;
    v.aluop = op; v.f3 = fn3; v.f7 = fn7; v.alusrc = src;
    v.rd1 = a; v.rd2 = b; v.imm = im; v.pc = 32'h0;
    v.memd = 32'h0; v.wbd = 32'h0; v.fa = 2'b00; v.fb = 2'b00;
    v.branch = 1'b0; v.regwrite = 1'b1; v.memwrite = 1'b0; v.memread = 1'b0;
    v.memtoreg = 1'b0; v.rd = 5'd1;
    v.e_res = res; v.e_store = b; v.e_target = im; v.e_regw = 1'b1; v.e_taken = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {o_res | o_store, 32'h0} == 64'h0 &&
              {o_memtoreg, o_regwrite, o_memread, o_memwrite, o_f3, o_rd} == 12'h0
              ? 32'h0 : 32'h1, 32'h0);
  endtask

  task automatic drive(input vec_t v);
    aluop = v.aluop; f3 = v.f3; f7 = v.f7; alusrc = v.alusrc;
    rd1 = v.rd1; rd2 = v.rd2; imm = v.imm; pc = v.pc;
    memd = v.memd; wbd = v.wbd; fa = v.fa; fb = v.fb;
    branch = v.branch; regwrite = v.regwrite; memwrite = v.memwrite;
    memread = v.memread; memtoreg = v.memtoreg; rd = v.rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // R-type SUB and SRA
    vecs.push_back(base(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE));
    vecs.push_back(base(2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000));
    // I-type ADD ignores func7, A from MEM forward
    v = base(2'b11, 3'b000, 1'b1, 1'b1, 32'h1234, 32'h55, 32'hFFFF_FFFF, 32'h0000_000F);
    v.fa = 2'b10; v.memd = 32'h10; vecs.push_back(v);
    // store data from WB forward even with ALUSrc=1
    v = base(2'b00, 3'b010, 1'b0, 1'b1, 32'h100, 32'h77, 32'h8, 32'h108);
    v.fb = 2'b01; v.wbd = 32'hAB; v.memwrite = 1'b1; v.regwrite = 1'b0;
    v.e_regw = 1'b0; v.e_store = 32'hAB; vecs.push_back(v);
    vecs.push_back(base(2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1));
    vecs.push_back(base(2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd0));
    vecs.push_back(base(2'b10, 3'b001, 1'b0, 1'b0, 32'd1, 32'h23, 32'h0, 32'd8));
    vecs.push_back(base(2'b11, 3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h4, 32'h0800_0000));
    vecs.push_back(base(2'b01, 3'b000, 1'b0, 1'b0, 32'd3, 32'd5, 32'h0, 32'hFFFF_FFFE));
    vecs.push_back(base(2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0FF0));
    vecs.push_back(base(2'b10, 3'b110, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'hFFF0));
    vecs.push_back(base(2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'hF000));
    vecs.push_back(base(2'b11, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'h404, 32'hF800_0000));
    // select 11 behaves like 00
    v = base(2'b00, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 32'h0, 32'd5);
    v.fa = 2'b11; v.fb = 2'b11; v.memd = 32'd99; v.wbd = 32'd77; vecs.push_back(v);
    vecs.push_back(base(2'b10, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 32'd12));
    vecs.push_back(base(2'b11, 3'b001, 1'b1, 1'b1, 32'd3, 32'h0, 32'd2, 32'd12));
    // branches: A=-1, B=1, PC=0x100, imm=-8
    for (int i = 0; i < 5; i++) begin
      logic [2:0] bf3 [5] = '{3'b100, 3'b110, 3'b010, 3'b101, 3'b111};
      logic       btk [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      v = base(2'b01, bf3[i], 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'hFFFF_FFFE);
      v.branch = 1'b1; v.pc = 32'h100; v.regwrite = 1'b0; v.e_regw = 1'b0;
      v.e_taken = btk[i]; v.e_target = 32'hF8; vecs.push_back(v);
    end
    // EQ/NE on a forwarded rs2, and Branch=0 gating
    for (int i = 0; i < 3; i++) begin
      v = base(2'b01, (i == 1) ? 3'b001 : 3'b000, 1'b0, 1'b0, 32'd5, 32'd0, 32'h10, 32'd0);
      v.fb = 2'b10; v.memd = 32'd5; v.e_store = 32'd5;
      v.branch = (i != 2); v.pc = 32'h200; v.regwrite = 1'b0; v.e_regw = 1'b0;
      v.e_taken = (i == 0); v.e_target = 32'h210; vecs.push_back(v);
    end
    // rd=x0 suppresses the write; rd=3 does not
    v = base(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'h0, 32'd2);
    v.rd = 5'd0; v.e_regw = 1'b0; v.memread = 1'b1; v.memtoreg = 1'b1; vecs.push_back(v);
    v.rd = 5'd3; v.e_regw = 1'b1; vecs.push_back(v);

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(vecs[0]);
    #1;
    chk_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      string n;
      @(negedge clk);
      drive(vecs[i]);
      #1;
      n = $sformatf("v%0d", i);
      chk({n, "_taken"}, 32'(taken), 32'(vecs[i].e_taken));
      chk({n, "_target"}, target, vecs[i].e_target);
      @(posedge clk);
      #1;
      chk({n, "_res"}, o_res, vecs[i].e_res);
      chk({n, "_store"}, o_store, vecs[i].e_store);
      chk({n, "_regw"}, 32'(o_regwrite), 32'(vecs[i].e_regw));
      chk({n, "_rd"}, 32'(o_rd), 32'(vecs[i].rd));
      chk({n, "_func3"}, 32'(o_f3), 32'(vecs[i].f3));
      chk({n, "_ctl"}, 32'({o_memwrite, o_memread, o_memtoreg}),
          32'({vecs[i].memwrite, vecs[i].memread, vecs[i].memtoreg}));
    end

    // stall holds for two cycles while inputs change
    @(negedge clk); drive(vecs[0]);
    @(posedge clk); #1; chk("stall_pre_res", o_res, 32'hFFFF_FFFE);
    @(negedge clk); drive(vecs[9]); stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold%0d_res", c), o_res, 32'hFFFF_FFFE);
      chk($sformatf("stall_hold%0d_store", c), o_store, 32'd7);
      chk($sformatf("stall_hold%0d_rd", c), 32'(o_rd), 32'd1);
    end
    // flush wins over stall
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; chk_zero("stall_flush_bubble");
    @(negedge clk); flush = 1'b0; stall = 1'b0; drive(vecs[1]);
    @(posedge clk); #1; chk("after_flush_res", o_res, 32'hF800_0000);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; chk_zero("flush_only_bubble");
    @(negedge clk); flush = 1'b0; drive(vecs[10]);
    @(posedge clk); #1; chk("pre_reset_res", o_res, 32'hFFF0);

    // asynchronous reset clears outputs with no clock edge
    @(negedge clk); drive(vecs[11]);
    #2 rst = 1'b0;
    #1 chk_zero("async_reset_clear");
    @(negedge clk); chk_zero("reset_held");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_load_res", o_res, 32'hF000);
    chk("post_reset_load_regw", 32'(o_regwrite), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
